seven_segment_mux: RTL and testbench

Parametrised multiplexed seven-segment display driver for the board top level, succeeding the fixed 4-digit hex driver. Scans `num_digits` common-anode/cathode digits, and displays either a hex value or an unsigned decimal value produced by an on-block sequential binary-to-BCD (double-dabble) converter, with overflow indication. Sits between processor-visible state (e.g. a register-file word) and the board's `seg`/`an` pins.

---
 rtl/seven_segment_mux.sv | 234 +++++++++++++++++++++++
 tb/tb_seven_segment_mux.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux.sv
// seven_segment_mux
//   Multiplexed seven-segment display driver. Shows a loaded value either as
//   hex or as unsigned decimal. Decimal values go through a sequential
//   double-dabble converter (one bit per clock). A value too large for the
//   available digits shows dashes on every digit and raises ovf.
//
//   Optional build macro: SEVEN_SEG_LZB_EN
//     defined     -> decimal results blank leading zero digits above digit 0
//     not defined -> every digit is always shown (blank flags held at 0)
//
// Parameters
//   num_digits   digits driven; inp is 4*num_digits bits wide
//   clkdiv_ratio clk cycles each digit stays selected while scanning (>=2)
//   active_low   1: sel and data are active-low, 0: active-high
//
// Ports
//   clk   in   single clock, rising edge
//   rst   in   synchronous active-high reset
//   inp   in   value to display, sampled only on an accepted load
//   load  in   sample inp and mode; accepted only while busy is low
//   mode  in   0 = hex, 1 = unsigned decimal
//   busy  out  decimal conversion running (mirrors the FSM state)
//   ovf   out  last decimal value did not fit in num_digits digits
//   sel   out  one-hot digit enable, bit 0 = rightmost digit
//   data  out  segments {g,f,e,d,c,b,a}
//
// Handshake: a load is accepted on a rising edge where load=1 and busy=0.
// Loads seen while busy=1 are dropped, never queued. On the edge that ends
// a conversion busy is still 1, so a load there is dropped; a load on the
// following edge is accepted.
module seven_segment_mux #(
  parameter int num_digits   = 4,
  parameter int clkdiv_ratio = 10000,
  parameter int active_low   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*num_digits-1:0] inp,
  input  logic                    load,
  input  logic                    mode,
  output logic                    busy,
  output logic                    ovf,
  output logic [num_digits-1:0]   sel,
  output logic [6:0]              data
);

  localparam int W  = 4 * num_digits;        // binary input width
  localparam int BW = 4 * (num_digits + 1);  // BCD scratch, one spare digit
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int PW = (clkdiv_ratio > 1) ? $clog2(clkdiv_ratio) : 1;
  localparam int IW = (num_digits > 1) ? $clog2(num_digits) : 1;

  localparam logic [num_digits-1:0] SEL0     = num_digits'(1);
  localparam logic [num_digits-1:0] SEL_RST  = (active_low != 0) ? ~SEL0 : SEL0;
  localparam logic [6:0]            DATA_RST = (active_low != 0) ? ~7'h3F : 7'h3F;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      shift_q, shift_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              lost_q, lost_d;     // a BCD bit fell off the top
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        nib_q [num_digits];
  logic [3:0]        nib_d [num_digits];
  logic [num_digits-1:0] blank_q, blank_d;
  logic              dash_q, dash_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [num_digits-1:0] sel_q, sel_d;
  logic [6:0]        data_q, data_d;

  // datapath temporaries
  logic [BW-1:0]     adj;
  logic [BW+W-1:0]   step;
  logic              lost_step;
  logic              ovf_res;
  logic              lz_run;
  logic [num_digits-1:0] onehot;
  logic [6:0]        seg;

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  // FSM next state plus conversion / display datapath
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    lost_d  = lost_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    blank_d = blank_q;
    dash_d  = dash_q;
    ovf_d   = ovf_q;
    ovf_res = 1'b0;
    lz_run  = 1'b1;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift.
    adj = bcd_q;
    for (int d = 0; d < num_digits + 1; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    step      = {adj, shift_q} << 1;
    lost_step = lost_q | adj[BW-1];

    case (state_q)
      IDLE: begin
        if (load) begin
          if (mode) begin
            shift_d = inp;
            bcd_d   = '0;
            lost_d  = 1'b0;
            cnt_d   = '0;
            state_d = CONV;
          end else begin
            for (int i = 0; i < num_digits; i++) nib_d[i] = inp[4*i +: 4];
            blank_d = '0;
            dash_d  = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end
      CONV: begin
        shift_d = step[W-1:0];
        bcd_d   = step[BW+W-1:W];
        lost_d  = lost_step;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          // Final iteration: publish the result on this same edge so the
          // display never shows partial digits.
          state_d = IDLE;
          ovf_res = lost_step | (bcd_d[BW-1 -: 4] != 4'd0);
          ovf_d   = ovf_res;
          dash_d  = ovf_res;
          blank_d = '0;
          if (!ovf_res) begin
            for (int i = 0; i < num_digits; i++) nib_d[i] = bcd_d[4*i +: 4];
`ifdef SEVEN_SEG_LZB_EN
            // Blank digit i when it and every digit above it are zero;
            // digit 0 always shows so a zero value reads "0".
            for (int i = num_digits - 1; i >= 1; i--) begin
              lz_run     = lz_run & (bcd_d[4*i +: 4] == 4'd0);
              blank_d[i] = lz_run;
            end
`else
            blank_d = '0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan counter and registered pin drive. Pins follow the next scan index
  // so sel switches on the edge the index advances, and follow the current
  // display register so data lags a display update by one cycle.
  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PW'(clkdiv_ratio - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IW'(num_digits - 1)) ? '0 : idx_q + IW'(1);
    end

    onehot        = '0;
    onehot[idx_d] = 1'b1;

    if (dash_q)              seg = 7'b1000000;
    else if (blank_q[idx_d]) seg = 7'b0000000;
    else                     seg = font(nib_q[idx_d]);

    sel_d  = (active_low != 0) ? ~onehot : onehot;
    data_d = (active_low != 0) ? ~seg : seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      lost_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < num_digits; i++) nib_q[i] <= 4'd0;
      blank_q <= '0;
      dash_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      sel_q   <= SEL_RST;
      data_q  <= DATA_RST;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      lost_q  <= lost_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < num_digits; i++) nib_q[i] <= nib_d[i];
      blank_q <= blank_d;
      dash_q  <= dash_d;
      ovf_q   <= ovf_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign busy = (state_q == CONV);
  assign ovf  = ovf_q;
  assign sel  = sel_q;
  assign data = data_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: 4 digits, prescaler 4, active-low pins.
module tb_seven_segment_mux;

  localparam int ND  = 4;
  localparam int W   = 16;
  localparam int DIV = 4;
`ifdef SEVEN_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  inp;
  logic          load;
  logic          mode;
  logic          busy;
  logic          ovf;
  logic [ND-1:0] sel;
  logic [6:0]    data;

  seven_segment_mux #(
    .num_digits(ND), .clkdiv_ratio(DIV), .active_low(1)
  ) dut (
    .clk(clk), .rst(rst), .inp(inp), .load(load), .mode(mode),
    .busy(busy), .ovf(ovf), .sel(sel), .data(data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        mode;
    logic [15:0] inp;
    logic        exp_ovf;
    logic [15:0] exp_nib;  // expected digit values, digit 0 in bits 3:0
    int          sig;      // significant decimal digits (for blanking)
  } vec_t;

  vec_t       vecs [12];
  logic [6:0] exp_q [$];
  logic [6:0] font_al [16];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // expected pin values of the four digits for a vector
  task automatic push_expected(input vec_t v);
    for (int i = 0; i < ND; i++) begin
      if (v.exp_ovf)                     exp_q.push_back(7'b0111111);
      else if (LZB && v.mode && i >= v.sig) exp_q.push_back(7'b1111111);
      else                               exp_q.push_back(font_al[v.exp_nib[4*i +: 4]]);
    end
  endtask

  // follow the scan, pop one expected pattern as each digit is selected
  task automatic scan_check(input string name);
    logic [ND-1:0] want_sel;
    logic [6:0]    want;
    int            n;
    for (int i = 0; i < ND; i++) begin
      want_sel = ~(4'b0001 << i);
      n = 0;
      while (sel !== want_sel && n < 64) begin
        @(negedge clk);
        n++;
      end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 7'bxxxxxxx;
      if (n >= 64) begin
        total++;
        bad++;
        $display("FAIL %s_timeout digit%0d: sel=%b want %b", name, i, sel, want_sel);
      end else begin
        check($sformatf("%s_digit%0d", name, i), {25'd0, data}, {25'd0, want});
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_vec(input string name, input vec_t v, input bit interfere);
    int cnt;
    @(negedge clk);
    load = 1'b1;
    mode = v.mode;
    inp  = v.inp;
    @(negedge clk);
    load = 1'b0;
    inp  = 16'($urandom_range(0, 65535));
    cnt  = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (interfere && cnt == 5) begin
        load = 1'b1;
        mode = 1'b0;
        inp  = 16'hFFFF;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check({name, "_busy_cycles"}, cnt, v.mode ? 16 : 0);
    check({name, "_ovf"}, {31'd0, ovf}, {31'd0, v.exp_ovf});
    push_expected(v);
    repeat (2) @(negedge clk);
    scan_check(name);
  endtask

  function automatic vec_t dec_vec(input int val);
    vec_t v;
    v.mode    = 1'b1;
    v.inp     = 16'(val);
    v.exp_ovf = (val > 9999);
    v.exp_nib = '0;
    v.sig     = 1;
    for (int i = 0; i < ND; i++) begin
      v.exp_nib[4*i +: 4] = 4'((val / (10 ** i)) % 10);
      if (i > 0 && val >= 10 ** i) v.sig = i + 1;
    end
    return v;
  endfunction

  function automatic vec_t hex_vec(input logic [15:0] val);
    vec_t v;
    v.mode = 1'b0; v.inp = val; v.exp_ovf = 1'b0; v.exp_nib = val; v.sig = 4;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    vec_t v;
    logic [ND-1:0] want_sel;
    int cnt;

    font_al = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0]  = '{1'b0, 16'h1A3F, 1'b0, 16'h1A3F, 4};
    vecs[1]  = '{1'b1, 16'd1234, 1'b0, 16'h1234, 4};
    vecs[2]  = '{1'b1, 16'd12345, 1'b1, 16'h0000, 4};
    vecs[3]  = '{1'b1, 16'd42,   1'b0, 16'h0042, 2};
    vecs[4]  = '{1'b1, 16'd0,    1'b0, 16'h0000, 1};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 4};
    vecs[6]  = '{1'b1, 16'd9999, 1'b0, 16'h9999, 4};
    vecs[7]  = '{1'b1, 16'd10000, 1'b1, 16'h0000, 4};
    vecs[8]  = '{1'b0, 16'hFEDC, 1'b0, 16'hFEDC, 4};
    vecs[9]  = '{1'b1, 16'd1000, 1'b0, 16'h1000, 4};
    vecs[10] = '{1'b1, 16'd7,    1'b0, 16'h0007, 1};
    vecs[11] = '{1'b1, 16'd65535, 1'b1, 16'h0000, 4};

    rst = 1'b1; load = 1'b0; mode = 1'b0; inp = '0;
    repeat (3) @(negedge clk);

    // reset state, then scan rotation: each digit held exactly DIV cycles
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    check("rst_data", {25'd0, data}, {25'd0, 7'b1000000});
    for (int j = 0; j < 4 * DIV + 1; j++) begin
      want_sel = ~(4'b0001 << ((j / DIV) % ND));
      check($sformatf("scan_sel_%0d", j), {28'd0, sel}, {28'd0, want_sel});
      @(negedge clk);
    end

    for (int k = 0; k < 12; k++) run_vec($sformatf("vec%0d", k), vecs[k], 1'b0);

    for (int k = 0; k < 3; k++) begin
      run_vec($sformatf("rnd_hex%0d", k), hex_vec(16'($urandom_range(0, 65535))), 1'b0);
      run_vec($sformatf("rnd_dec%0d", k), dec_vec($urandom_range(0, 9999)), 1'b0);
    end

    // load during conversion is dropped
    run_vec("ignored_load", dec_vec(99), 1'b1);

    // reset in the middle of a conversion, with ovf set beforehand
    run_vec("pre_rst", dec_vec(65535), 1'b0);
    @(negedge clk);
    load = 1'b1; mode = 1'b1; inp = 16'd1234;
    @(negedge clk);
    load = 1'b0;
    cnt = 1;
    while (busy === 1'b1 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ovf",  {31'd0, ovf},  32'd0);
    check("midrst_sel",  {28'd0, sel},  {28'd0, 4'b1110});
    check("midrst_data", {25'd0, data}, {25'd0, 7'b1000000});
    repeat (ND) exp_q.push_back(font_al[0]);
    scan_check("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
